dram_host_issuer: RTL and testbench

//  Synthesizable initiator for the controller command/data interface; drives the controller's command/valid/write_data inputs and consumes read_data/read_data_valid/ba_cmd_pm.

---
 rtl/dram_host_issuer_pkg.sv | 26 ++
 rtl/dram_rd_ret_fifo.sv | 58 +++++
 rtl/dram_host_issuer.sv | 195 +++++++++++++++++++
 tb/tb_dram_host_issuer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_host_issuer_pkg.sv
// Shared types for the DRAM host issuer: controller command format, data-bus
// width, bank count and the issuer FSM state encoding.
package dram_host_issuer_pkg;

  localparam int DQ_BITS  = 8;
  localparam int DATA_W   = DQ_BITS * 8;
  localparam int BANK_NUM = 4;
  localparam int ROW_W    = 14;
  localparam int COL_W    = 10;

  // r_w: 1 = read, 0 = write
  typedef struct packed {
    logic             r_w;
    logic [1:0]       bank_addr;
    logic [ROW_W-1:0] row_addr;
    logic [COL_W-1:0] col_addr;
  } command_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } issuer_state_t;

endpackage

// File: rtl/dram_rd_ret_fifo.sv
// Synchronous read-return FIFO used when RD_RET_FIFO_EN is defined.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_i, din_i  write side (push ignored when full)
//   pop_i, dout_o  read side, dout_o shows the head entry (pop ignored when empty)
//   count_o        number of stored entries
//   full_o/empty_o occupancy flags
// DEPTH must be a power of two, at least 2.
module dram_rd_ret_fifo
  import dram_host_issuer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = DATA_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/dram_host_issuer.sv
// Host-side command issuer for the DRAM controller.
// Accepts one host request at a time (valid/ready), holds it until its bank is
// idle and the read budget allows, then drives it to the controller with a
// single-cycle valid strobe. Tracks reads in flight, returns read data in order
// and can drain all outstanding reads on a flush request.
// Ports:
//   clk, power_on_rst                          clock, asynchronous active-high reset
//   host_req_valid/ready/cmd/wdata             host request channel
//   flush_req / flush_done                     drain request / completion pulse
//   command, valid, write_data                 controller command channel
//   ba_cmd_pm                                  per-bank busy from controller
//   read_data, read_data_valid                 controller read return
//   host_rd_valid, host_rd_data, host_rd_ready host read return
//   err_underflow                              sticky: return with nothing outstanding
// Build option: define RD_RET_FIFO_EN to buffer read returns in a FIFO of
// RFIFO_DEPTH entries with host_rd_ready backpressure; otherwise returns are
// forwarded one cycle later and host_rd_ready is ignored.
module dram_host_issuer
  import dram_host_issuer_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int RFIFO_DEPTH     = 4
) (
  input  logic                clk,
  input  logic                power_on_rst,
  input  logic                host_req_valid,
  output logic                host_req_ready,
  input  command_t            host_req_cmd,
  input  logic [DATA_W-1:0]   host_req_wdata,
  input  logic                flush_req,
  output logic                flush_done,
  output command_t            command,
  output logic                valid,
  output logic [DATA_W-1:0]   write_data,
  input  logic [BANK_NUM-1:0] ba_cmd_pm,
  input  logic [DATA_W-1:0]   read_data,
  input  logic                read_data_valid,
  output logic                host_rd_valid,
  output logic [DATA_W-1:0]   host_rd_data,
  input  logic                host_rd_ready,
  output logic                err_underflow
);

  issuer_state_t     state_q, state_d;
  command_t          hold_cmd_q, command_q;
  logic [DATA_W-1:0] hold_wdata_q, write_data_q;
  logic [7:0]        outstanding_q, outstanding_d;
  logic              flush_pend_q, flush_pend_d;
  logic              err_underflow_q;

  logic handshake, bank_busy, rd_budget_ok, issue_ok, issue_fire;
  logic rd_issue, rd_ret_match;

  assign handshake    = host_req_valid && host_req_ready;
  assign bank_busy    = ba_cmd_pm[hold_cmd_q.bank_addr];
  assign issue_ok     = !bank_busy && (!hold_cmd_q.r_w || rd_budget_ok);
  assign issue_fire   = (state_q == ST_PEND) && issue_ok;
  assign rd_issue     = issue_fire && hold_cmd_q.r_w;
  // A return with nothing in flight is an error and must not wrap the count.
  assign rd_ret_match = read_data_valid && (outstanding_q != '0);

  assign outstanding_d = outstanding_q + 8'(rd_issue) - 8'(rd_ret_match);

`ifdef RD_RET_FIFO_EN
  logic [$clog2(RFIFO_DEPTH):0] fifo_count;
  logic                         fifo_empty;
  logic                         fifo_full_unused;

  // Reads in flight plus buffered returns must fit the FIFO, so a return can
  // always be pushed even while the host stalls.
  assign rd_budget_ok = (outstanding_q != 8'(MAX_OUTSTANDING)) &&
                        ((9'(outstanding_q) + 9'(fifo_count)) < 9'(RFIFO_DEPTH));

  dram_rd_ret_fifo #(
    .DEPTH (RFIFO_DEPTH),
    .W     (DATA_W)
  ) u_rd_ret_fifo (
    .clk_i   (clk),
    .rst_i   (power_on_rst),
    .push_i  (read_data_valid),
    .din_i   (read_data),
    .pop_i   (host_rd_valid && host_rd_ready),
    .dout_o  (host_rd_data),
    .count_o (fifo_count),
    .full_o  (fifo_full_unused),
    .empty_o (fifo_empty)
  );

  assign host_rd_valid = !fifo_empty;
`else
  logic              host_rd_valid_q;
  logic [DATA_W-1:0] host_rd_data_q;
  logic              unused_host_rd_ready;
  localparam int     unused_rfifo_depth = RFIFO_DEPTH;

  assign unused_host_rd_ready = host_rd_ready;
  assign rd_budget_ok         = (outstanding_q != 8'(MAX_OUTSTANDING));

  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      host_rd_valid_q <= 1'b0;
      host_rd_data_q  <= '0;
    end else begin
      host_rd_valid_q <= read_data_valid;
      host_rd_data_q  <= read_data;
    end
  end

  assign host_rd_valid = host_rd_valid_q;
  assign host_rd_data  = host_rd_data_q;
`endif

  // State register
  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      state_q      <= ST_IDLE;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Next-state logic. A flush that arrives alongside an accepted request (or
  // while one is pending) is remembered and serviced once that command issues.
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          state_d = ST_PEND;
          if (flush_req) flush_pend_d = 1'b1;
        end else if (flush_req || flush_pend_q) begin
          state_d      = ST_DRAIN;
          flush_pend_d = 1'b0;
        end
      end
      ST_PEND: begin
        if (flush_req) flush_pend_d = 1'b1;
        if (issue_ok)  state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (handshake) begin
          state_d = ST_PEND;
          if (flush_req) flush_pend_d = 1'b1;
        end else if (flush_req || flush_pend_q) begin
          state_d      = ST_DRAIN;
          flush_pend_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (outstanding_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    host_req_ready = !power_on_rst && ((state_q == ST_IDLE) || (state_q == ST_ISSUE));
    valid          = (state_q == ST_ISSUE);
    flush_done     = (state_q == ST_DRAIN) && (outstanding_q == '0);
  end

  // Hold register, controller command registers and read bookkeeping
  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      hold_cmd_q      <= '0;
      hold_wdata_q    <= '0;
      command_q       <= '0;
      write_data_q    <= '0;
      outstanding_q   <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      if (handshake) begin
        hold_cmd_q   <= host_req_cmd;
        hold_wdata_q <= host_req_wdata;
      end
      if (issue_fire) begin
        command_q    <= hold_cmd_q;
        write_data_q <= hold_cmd_q.r_w ? '0 : hold_wdata_q;
      end
      outstanding_q <= outstanding_d;
      if (read_data_valid && (outstanding_q == '0)) err_underflow_q <= 1'b1;
    end
  end

  assign command       = command_q;
  assign write_data    = write_data_q;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_dram_host_issuer.sv
module tb_dram_host_issuer;
  import dram_host_issuer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                power_on_rst;
  logic                host_req_valid;
  command_t            host_req_cmd;
  logic [DATA_W-1:0]   host_req_wdata;
  logic                flush_req;
  logic [BANK_NUM-1:0] ba_cmd_pm;
  logic [DATA_W-1:0]   read_data;
  logic                read_data_valid;
  logic                host_rd_ready;

  // DUT A: MAX_OUTSTANDING=2, DUT B: default MAX_OUTSTANDING=8. Shared stimulus.
  logic a_ready, a_valid, a_fd, a_rdv, a_err, b_ready, b_valid, b_fd, b_rdv, b_err;
  command_t a_cmd, b_cmd;
  logic [DATA_W-1:0] a_wd, a_rdd, b_wd, b_rdd;

  dram_host_issuer #(.MAX_OUTSTANDING(2), .RFIFO_DEPTH(4)) u_a (
    .clk(clk), .power_on_rst(power_on_rst), .host_req_valid(host_req_valid),
    .host_req_ready(a_ready), .host_req_cmd(host_req_cmd), .host_req_wdata(host_req_wdata),
    .flush_req(flush_req), .flush_done(a_fd), .command(a_cmd), .valid(a_valid),
    .write_data(a_wd), .ba_cmd_pm(ba_cmd_pm), .read_data(read_data),
    .read_data_valid(read_data_valid), .host_rd_valid(a_rdv), .host_rd_data(a_rdd),
    .host_rd_ready(host_rd_ready), .err_underflow(a_err));

  dram_host_issuer #(.MAX_OUTSTANDING(8), .RFIFO_DEPTH(4)) u_b (
    .clk(clk), .power_on_rst(power_on_rst), .host_req_valid(host_req_valid),
    .host_req_ready(b_ready), .host_req_cmd(host_req_cmd), .host_req_wdata(host_req_wdata),
    .flush_req(flush_req), .flush_done(b_fd), .command(b_cmd), .valid(b_valid),
    .write_data(b_wd), .ba_cmd_pm(ba_cmd_pm), .read_data(read_data),
    .read_data_valid(read_data_valid), .host_rd_valid(b_rdv), .host_rd_data(b_rdd),
    .host_rd_ready(host_rd_ready), .err_underflow(b_err));

  int n_vec = 0;
  int n_err = 0;
  int vcnt_a = 0;
  int vcnt_b = 0;
  int rdcnt_a = 0;

  always @(posedge clk) begin
    if (a_valid) vcnt_a <= vcnt_a + 1;
    if (b_valid) vcnt_b <= vcnt_b + 1;
    if (a_rdv && host_rd_ready) rdcnt_a <= rdcnt_a + 1;
  end

  typedef struct {
    logic        r_w;
    logic [1:0]  bank;
    logic [3:0]  pm;
    logic [63:0] wdata;
    logic [63:0] exp_wd;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic command_t mk(input logic rw, input logic [1:0] b,
                                  input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
    command_t c;
    c.r_w = rw;
    c.bank_addr = b;
    c.row_addr = row;
    c.col_addr = col;
    return c;
  endfunction

  task automatic do_reset();
    power_on_rst    = 1'b1;
    host_req_valid  = 1'b0;
    host_req_cmd    = '0;
    host_req_wdata  = '0;
    flush_req       = 1'b0;
    ba_cmd_pm       = '0;
    read_data       = '0;
    read_data_valid = 1'b0;
    host_rd_ready   = 1'b1;
    tick();
    tick();
    power_on_rst = 1'b0;
    tick();
  endtask

  // Present a request and hold it until the selected DUT accepts it.
  task automatic push_req(input logic sel_b, input command_t c, input logic [63:0] d);
    logic rdy;
    host_req_valid = 1'b1;
    host_req_cmd   = c;
    host_req_wdata = d;
    rdy = sel_b ? b_ready : a_ready;
    for (int i = 0; i < 50 && !rdy; i++) begin
      tick();
      rdy = sel_b ? b_ready : a_ready;
    end
    chk("push_accept_timeout", 64'(rdy), 64'(1));
    tick();
    host_req_valid = 1'b0;
  endtask

  task automatic ret(input logic [63:0] d);
    read_data_valid = 1'b1;
    read_data       = d;
    tick();
    read_data_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap, blocked_hits;
    command_t c;

    vecs[0] = '{1'b0, 2'd2, 4'b0000, 64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5, 8'd0};
    vecs[1] = '{1'b1, 2'd0, 4'b1110, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0,                    8'd1};
    vecs[2] = '{1'b0, 2'd3, 4'b0111, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'd0};
    vecs[3] = '{1'b1, 2'd1, 4'b1101, 64'hFFFF_0000_FFFF_0000, 64'h0,                    8'd1};

    // Reset values
    power_on_rst = 1'b1;
    host_req_valid = 1'b0; host_req_cmd = '0; host_req_wdata = '0; flush_req = 1'b0;
    ba_cmd_pm = '0; read_data = '0; read_data_valid = 1'b0; host_rd_ready = 1'b1;
    tick();
    chk("rst_ready", 64'(a_ready), 64'(0));
    chk("rst_valid", 64'(a_valid), 64'(0));
    chk("rst_command", 64'(a_cmd), 64'(0));
    chk("rst_wdata", a_wd, 64'(0));
    chk("rst_flush_done", 64'(a_fd), 64'(0));
    chk("rst_rd_valid", 64'(a_rdv), 64'(0));
    chk("rst_err", 64'(a_err), 64'(0));
    power_on_rst = 1'b0;
    tick();
    chk("post_rst_ready", 64'(a_ready), 64'(1));

    // Single-command issue, table-driven over banks / busy masks / directions
    for (int i = 0; i < 4; i++) begin
      do_reset();
      ba_cmd_pm = vecs[i].pm;
      c = mk(vecs[i].r_w, vecs[i].bank, ROW_W'(14'h1000 + i), COL_W'(10'h020 + i));
      host_req_valid = 1'b1;
      host_req_cmd   = c;
      host_req_wdata = vecs[i].wdata;
      chk("t1_ready_idle", 64'(a_ready), 64'(1));
      tick();
      host_req_valid = 1'b0;
      chk("t1_valid_after_accept", 64'(a_valid), 64'(0));
      chk("t1_ready_pend", 64'(a_ready), 64'(0));
      tick();
      chk("t1_valid_issue", 64'(a_valid), 64'(1));
      chk("t1_command", 64'(a_cmd), 64'(c));
      chk("t1_write_data", a_wd, vecs[i].exp_wd);
      chk("t1_outstanding", 64'(u_a.outstanding_q), 64'(vecs[i].exp_out));
      tick();
      chk("t1_valid_one_cycle", 64'(a_valid), 64'(0));
      chk("t1_command_held", 64'(a_cmd), 64'(c));
      chk("t1_ready_after", 64'(a_ready), 64'(1));
    end

    // Bank busy blocks issue until its bit clears
    do_reset();
    ba_cmd_pm = 4'b0010;
    push_req(1'b0, mk(1'b1, 2'd1, 14'h0042, 10'h011), 64'h0);
    blocked_hits = 0;
    for (int k = 0; k < 5; k++) begin
      if (a_valid) blocked_hits++;
      tick();
    end
    chk("t2_no_valid_blocked", 64'(blocked_hits + int'(a_valid)), 64'(0));
    ba_cmd_pm = 4'b0000;
    tick();
    chk("t2_valid_unblocked", 64'(a_valid), 64'(1));
    chk("t2_outstanding", 64'(u_a.outstanding_q), 64'(1));

    // Read budget (A has MAX_OUTSTANDING=2), in-order returns
    do_reset();
    snap = rdcnt_a;
    push_req(1'b0, mk(1'b1, 2'd0, 14'h0001, 10'h001), 64'h0);
    push_req(1'b0, mk(1'b1, 2'd1, 14'h0002, 10'h002), 64'h0);
    push_req(1'b0, mk(1'b1, 2'd2, 14'h0003, 10'h003), 64'h0);
    tick();
    chk("t3_third_held_valid", 64'(a_valid), 64'(0));
    tick();
    chk("t3_third_held_valid2", 64'(a_valid), 64'(0));
    chk("t3_ready_pend", 64'(a_ready), 64'(0));
    chk("t3_outstanding_max", 64'(u_a.outstanding_q), 64'(2));
    ret(64'h1111_0000_0000_0001);
    chk("t3_rd1_valid", 64'(a_rdv), 64'(1));
    chk("t3_rd1_data", a_rdd, 64'h1111_0000_0000_0001);
    chk("t3_not_yet_issued", 64'(a_valid), 64'(0));
    tick();
    chk("t3_third_issued", 64'(a_valid), 64'(1));
    chk("t3_outstanding_refill", 64'(u_a.outstanding_q), 64'(2));
    tick();
    ret(64'h2222_0000_0000_0002);
    chk("t3_rd2_data", a_rdd, 64'h2222_0000_0000_0002);
    ret(64'h3333_0000_0000_0003);
    chk("t3_rd3_data", a_rdd, 64'h3333_0000_0000_0003);
    tick();
    chk("t3_rd_valid_low", 64'(a_rdv), 64'(0));
    chk("t3_rd_pulses", 64'(rdcnt_a - snap), 64'(3));
    chk("t3_outstanding_zero", 64'(u_a.outstanding_q), 64'(0));

    // Simultaneous issue and return, then underflow
    do_reset();
    push_req(1'b0, mk(1'b1, 2'd0, 14'h0010, 10'h010), 64'h0);
    tick();
    push_req(1'b0, mk(1'b1, 2'd3, 14'h0011, 10'h011), 64'h0);
    read_data_valid = 1'b1;
    read_data = 64'h4444;
    tick();
    read_data_valid = 1'b0;
    chk("t4_issue_with_ret_valid", 64'(a_valid), 64'(1));
    chk("t4_outstanding_unchanged", 64'(u_a.outstanding_q), 64'(1));
    tick();
    ret(64'h5555);
    chk("t4_outstanding_zero", 64'(u_a.outstanding_q), 64'(0));
    chk("t4_no_err_yet", 64'(a_err), 64'(0));
    ret(64'h6666);
    chk("t4_err_set", 64'(a_err), 64'(1));
    chk("t4_count_stays_zero", 64'(u_a.outstanding_q), 64'(0));
    tick();
    tick();
    chk("t4_err_sticky", 64'(a_err), 64'(1));

    // Flush with three reads outstanding (DUT B)
    do_reset();
    push_req(1'b1, mk(1'b1, 2'd0, 14'h0020, 10'h001), 64'h0);
    push_req(1'b1, mk(1'b1, 2'd1, 14'h0021, 10'h002), 64'h0);
    push_req(1'b1, mk(1'b1, 2'd2, 14'h0022, 10'h003), 64'h0);
    tick();
    chk("t5_b_outstanding", 64'(u_b.outstanding_q), 64'(3));
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("t5_ready_drain", 64'(b_ready), 64'(0));
    chk("t5_fd_early", 64'(b_fd), 64'(0));
    ret(64'h7001);
    chk("t5_fd_after_ret1", 64'(b_fd), 64'(0));
    ret(64'h7002);
    chk("t5_fd_after_ret2", 64'(b_fd), 64'(0));
    ret(64'h7003);
    chk("t5_fd_pulse", 64'(b_fd), 64'(1));
    chk("t5_ready_still_low", 64'(b_ready), 64'(0));
    tick();
    chk("t5_fd_one_cycle", 64'(b_fd), 64'(0));
    chk("t5_ready_back", 64'(b_ready), 64'(1));

    // Request and flush in the same cycle: request issues first, then drain
    do_reset();
    host_req_valid = 1'b1;
    host_req_cmd = mk(1'b0, 2'd3, 14'h0030, 10'h030);
    host_req_wdata = 64'hCAFE;
    flush_req = 1'b1;
    tick();
    host_req_valid = 1'b0;
    flush_req = 1'b0;
    chk("t5b_pend_ready", 64'(b_ready), 64'(0));
    tick();
    chk("t5b_valid", 64'(b_valid), 64'(1));
    tick();
    chk("t5b_fd", 64'(b_fd), 64'(1));
    chk("t5b_ready_drain", 64'(b_ready), 64'(0));
    tick();
    chk("t5b_ready_idle", 64'(b_ready), 64'(1));

    // Reset while a command is pending
    do_reset();
    push_req(1'b0, mk(1'b0, 2'd2, 14'h0040, 10'h040), 64'hBEEF);
    tick();
    tick();
    ba_cmd_pm = 4'b0001;
    push_req(1'b0, mk(1'b1, 2'd0, 14'h0041, 10'h041), 64'h0);
    tick();
    chk("t6_pend_no_valid", 64'(a_valid), 64'(0));
    snap = vcnt_a;
    power_on_rst = 1'b1;
    #1;
    chk("t6_rst_ready", 64'(a_ready), 64'(0));
    chk("t6_rst_command", 64'(a_cmd), 64'(0));
    ba_cmd_pm = 4'b0000;
    tick();
    tick();
    power_on_rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("t6_no_valid_pulse", 64'(vcnt_a - snap), 64'(0));
    chk("t6_command", 64'(a_cmd), 64'(0));
    chk("t6_write_data", a_wd, 64'(0));
    chk("t6_outstanding", 64'(u_a.outstanding_q), 64'(0));
    chk("t6_err", 64'(a_err), 64'(0));
    chk("t6_rd_valid", 64'(a_rdv), 64'(0));
    chk("t6_fd", 64'(a_fd), 64'(0));
    chk("t6_ready", 64'(a_ready), 64'(1));

`ifdef RD_RET_FIFO_EN
    // Return FIFO full with host stalled: 4 reads issue, the 5th waits
    do_reset();
    host_rd_ready = 1'b0;
    snap = vcnt_b;
    for (int k = 0; k < 5; k++)
      push_req(1'b1, mk(1'b1, 2'(k), 14'h0050, COL_W'(k)), 64'h0);
    for (int k = 0; k < 4; k++) tick();
    chk("tf_four_issued", 64'(vcnt_b - snap), 64'(4));
    for (int k = 0; k < 4; k++) ret(64'(k + 1));
    tick();
    tick();
    chk("tf_fifo_full_stall", 64'(vcnt_b - snap), 64'(4));
    chk("tf_head_data", b_rdd, 64'(1));
    host_rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("tf_fifth_issued", 64'(vcnt_b - snap), 64'(5));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
